// File: rtl/arm_pkg.sv
// Shared ARM core definitions: ALU command encodings, the decoded control word
// and the ID/EXE pipeline-control action decode.
package arm_pkg;

    localparam int unsigned CMD_W = 4;

    typedef enum logic [CMD_W-1:0] {
        EXE_ADD = 4'b0000,
        EXE_ADC = 4'b0001,
        EXE_SUB = 4'b0011,
        EXE_SBC = 4'b0100,
        EXE_AND = 4'b0101,
        EXE_ORR = 4'b0110,
        EXE_EOR = 4'b0111,
        EXE_CMP = 4'b1000,
        EXE_TST = 4'b1001,
        EXE_LDR = 4'b1010,
        EXE_STR = 4'b1011
    } exe_cmd_t;

    // exe_cmd kept as a raw vector so unlisted encodings pass through untouched
    typedef struct packed {
        logic [CMD_W-1:0] exe_cmd;
        logic             mem_read;
        logic             mem_write;
        logic             wb_en;
        logic             s;
        logic             b;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;

    typedef struct packed {
        ctrl_word_t ctrl;
        logic       valid;
    } ctrl_slot_t;

    typedef enum logic [2:0] {
        ACT_FREEZE,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_SQUASH,
        ACT_LOAD
    } pipe_action_t;

    // Fixed priority: freeze > flush > hazard bubble > condition-fail squash > load
    function automatic pipe_action_t decode_action(
        input logic freeze,
        input logic flush,
        input logic hazard,
        input logic valid,
        input logic cond_pass
    );
        pipe_action_t act;
        act = ACT_LOAD;
        if (freeze)                 act = ACT_FREEZE;
        else if (flush)             act = ACT_FLUSH;
        else if (hazard)            act = ACT_BUBBLE;
        else if (valid && !cond_pass) act = ACT_SQUASH;
        return act;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: async active-low reset, enable, synchronous clear.
// Clear only acts on enabled edges, so a hold always dominates a clear.
module pipe_reg #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            if (clr) q <= '0;
            else     q <= d;
        end
    end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures the decoded control word and ID operands,
// applying freeze / flush / hazard bubble / condition-fail squash in priority order.
module id_exe_reg
    import arm_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          flush,
    input  logic          hazard,
    input  logic          cond_pass,
    input  logic [3:0]    exe_cmd_in,
    input  logic          mem_read_in,
    input  logic          mem_write_in,
    input  logic          wb_en_in,
    input  logic          s_in,
    input  logic          b_in,
    input  logic [DW-1:0] pc_in,
    input  logic [DW-1:0] val_rn_in,
    input  logic [DW-1:0] val_rm_in,
    input  logic          imm_in,
    input  logic [11:0]   shift_operand_in,
    input  logic [23:0]   simm24_in,
    input  logic [RW-1:0] dest_in,
    input  logic [RW-1:0] src1_in,
    input  logic [RW-1:0] src2_in,
    input  logic          carry_in,
    input  logic          valid_in,
    output logic [3:0]    exe_cmd_out,
    output logic          mem_read_out,
    output logic          mem_write_out,
    output logic          wb_en_out,
    output logic          s_out,
    output logic          b_out,
    output logic [DW-1:0] pc_out,
    output logic [DW-1:0] val_rn_out,
    output logic [DW-1:0] val_rm_out,
    output logic          imm_out,
    output logic [11:0]   shift_operand_out,
    output logic [23:0]   simm24_out,
    output logic [RW-1:0] dest_out,
    output logic [RW-1:0] src1_out,
    output logic [RW-1:0] src2_out,
    output logic          carry_out,
    output logic          valid_out,
    output logic [15:0]   bubble_cnt
);

    localparam int unsigned SHIFT_W = 12;
    localparam int unsigned SIMM_W  = 24;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
        logic [DW-1:0]      pc;
        logic [DW-1:0]      val_rn;
        logic [DW-1:0]      val_rm;
        logic               imm;
        logic [SHIFT_W-1:0] shift_operand;
        logic [SIMM_W-1:0]  simm24;
        logic [RW-1:0]      dest;
        logic [RW-1:0]      src1;
        logic [RW-1:0]      src2;
        logic               carry;
    } data_word_t;

    localparam int unsigned CTRL_W = $bits(ctrl_slot_t);
    localparam int unsigned DATA_W = $bits(data_word_t);

    pipe_action_t action;
    logic         en;
    logic         ctrl_clr;
    logic         data_clr;
    ctrl_slot_t   ctrl_d;
    ctrl_slot_t   ctrl_q;
    data_word_t   data_d;
    data_word_t   data_q;

    // Single action decode drives the enables and clears of both register banks
    always_comb begin
        action   = decode_action(freeze, flush, hazard, valid_in, cond_pass);
        en       = 1'b1;
        ctrl_clr = 1'b0;
        data_clr = 1'b0;

        // Branches may present X on exe_cmd; store 0 so X never reaches EXE
        ctrl_d.ctrl.exe_cmd   = b_in ? CMD_W'(0) : exe_cmd_in;
        ctrl_d.ctrl.mem_read  = mem_read_in;
        ctrl_d.ctrl.mem_write = mem_write_in;
        ctrl_d.ctrl.wb_en     = wb_en_in;
        ctrl_d.ctrl.s         = s_in;
        ctrl_d.ctrl.b         = b_in;
        ctrl_d.valid          = valid_in;

        case (action)
            ACT_FREEZE: en = 1'b0;
            ACT_FLUSH: begin
                ctrl_clr = 1'b1;
                data_clr = 1'b1;
            end
            ACT_BUBBLE: ctrl_clr = 1'b1;
            ACT_SQUASH: begin
                ctrl_d.ctrl.mem_read  = 1'b0;
                ctrl_d.ctrl.mem_write = 1'b0;
                ctrl_d.ctrl.wb_en     = 1'b0;
                ctrl_d.ctrl.s         = 1'b0;
                ctrl_d.ctrl.b         = 1'b0;
                ctrl_d.valid          = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        data_d.pc            = pc_in;
        data_d.val_rn        = val_rn_in;
        data_d.val_rm        = val_rm_in;
        data_d.imm           = imm_in;
        data_d.shift_operand = shift_operand_in;
        data_d.simm24        = simm24_in;
        data_d.dest          = dest_in;
        data_d.src1          = src1_in;
        data_d.src2          = src2_in;
        data_d.carry         = carry_in;
    end

    pipe_reg #(.W(CTRL_W)) u_ctrl_reg (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (ctrl_clr),
        .d   (ctrl_d),
        .q   (ctrl_q)
    );

    pipe_reg #(.W(DATA_W)) u_data_reg (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (data_clr),
        .d   (data_d),
        .q   (data_q)
    );

    // Saturating bubble counter; only a real bubble (not flush/freeze) counts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (action == ACT_BUBBLE && bubble_cnt != {CNT_W{1'b1}}) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    assign exe_cmd_out       = ctrl_q.ctrl.exe_cmd;
    assign mem_read_out      = ctrl_q.ctrl.mem_read;
    assign mem_write_out     = ctrl_q.ctrl.mem_write;
    assign wb_en_out         = ctrl_q.ctrl.wb_en;
    assign s_out             = ctrl_q.ctrl.s;
    assign b_out             = ctrl_q.ctrl.b;
    assign valid_out         = ctrl_q.valid;
    assign pc_out            = data_q.pc;
    assign val_rn_out        = data_q.val_rn;
    assign val_rm_out        = data_q.val_rm;
    assign imm_out           = data_q.imm;
    assign shift_operand_out = data_q.shift_operand;
    assign simm24_out        = data_q.simm24;
    assign dest_out          = data_q.dest;
    assign src1_out          = data_q.src1;
    assign src2_out          = data_q.src2;
    assign carry_out         = data_q.carry;

`ifndef SYNTHESIS
    // Upstream must never request a load and a store in the same instruction
    a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst)
                                 !(mem_read_in && mem_write_in))
        else $error("id_exe_reg: mem_read_in and mem_write_in both high");
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: directed scenarios plus randomized
// stimulus against a priority-rule reference model.
module tb_id_exe_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 4;
    localparam int unsigned VW = 4 + 6 + 3*DW + 1 + 12 + 24 + 3*RW + 1 + 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          freeze, flush, hazard, cond_pass;
    logic [3:0]    exe_cmd_in;
    logic          mem_read_in, mem_write_in, wb_en_in, s_in, b_in;
    logic [DW-1:0] pc_in, val_rn_in, val_rm_in;
    logic          imm_in;
    logic [11:0]   shift_operand_in;
    logic [23:0]   simm24_in;
    logic [RW-1:0] dest_in, src1_in, src2_in;
    logic          carry_in, valid_in;

    logic [3:0]    exe_cmd_out;
    logic          mem_read_out, mem_write_out, wb_en_out, s_out, b_out;
    logic [DW-1:0] pc_out, val_rn_out, val_rm_out;
    logic          imm_out;
    logic [11:0]   shift_operand_out;
    logic [23:0]   simm24_out;
    logic [RW-1:0] dest_out, src1_out, src2_out;
    logic          carry_out, valid_out;
    logic [15:0]   bubble_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    id_exe_reg #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
        .cond_pass(cond_pass), .exe_cmd_in(exe_cmd_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .wb_en_in(wb_en_in), .s_in(s_in), .b_in(b_in),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in), .imm_in(imm_in),
        .shift_operand_in(shift_operand_in), .simm24_in(simm24_in), .dest_in(dest_in),
        .src1_in(src1_in), .src2_in(src2_in), .carry_in(carry_in), .valid_in(valid_in),
        .exe_cmd_out(exe_cmd_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .wb_en_out(wb_en_out), .s_out(s_out),
        .b_out(b_out), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
        .imm_out(imm_out), .shift_operand_out(shift_operand_out), .simm24_out(simm24_out),
        .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
        .carry_out(carry_out), .valid_out(valid_out), .bubble_cnt(bubble_cnt)
    );

    logic [VW-1:0] obs;
    assign obs = {exe_cmd_out, mem_read_out, mem_write_out, wb_en_out, s_out, b_out,
                  valid_out, pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
                  simm24_out, dest_out, src1_out, src2_out, carry_out, bubble_cnt};

    // Reference model state: what EXE should currently see
    logic [3:0]    m_cmd;
    logic          m_mr, m_mw, m_wb, m_s, m_b, m_valid, m_imm, m_carry;
    logic [DW-1:0] m_pc, m_rn, m_rm;
    logic [11:0]   m_sh;
    logic [23:0]   m_simm;
    logic [RW-1:0] m_dest, m_src1, m_src2;
    int            m_cnt;

    function automatic logic [VW-1:0] expv();
        return {m_cmd, m_mr, m_mw, m_wb, m_s, m_b, m_valid, m_pc, m_rn, m_rm, m_imm,
                m_sh, m_simm, m_dest, m_src1, m_src2, m_carry, 16'(m_cnt)};
    endfunction

    function automatic void model_zero(input bit clear_cnt);
        {m_cmd, m_mr, m_mw, m_wb, m_s, m_b, m_valid} = '0;
        {m_pc, m_rn, m_rm, m_imm, m_sh, m_simm, m_dest, m_src1, m_src2, m_carry} = '0;
        if (clear_cnt) m_cnt = 0;
    endfunction

    // Apply the priority rules for one rising edge using current inputs
    function automatic void model_edge();
        if (!rst) begin
            model_zero(1'b1);
            return;
        end
        if (freeze) return;
        if (flush) begin
            model_zero(1'b0);
            return;
        end
        m_pc = pc_in; m_rn = val_rn_in; m_rm = val_rm_in; m_imm = imm_in;
        m_sh = shift_operand_in; m_simm = simm24_in; m_dest = dest_in;
        m_src1 = src1_in; m_src2 = src2_in; m_carry = carry_in;
        if (hazard) begin
            {m_cmd, m_mr, m_mw, m_wb, m_s, m_b, m_valid} = '0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            return;
        end
        m_cmd = b_in ? 4'd0 : exe_cmd_in;
        if (valid_in && !cond_pass) begin
            {m_mr, m_mw, m_wb, m_s, m_b} = '0;
            m_valid = 1'b1;
        end else begin
            m_mr = mem_read_in; m_mw = mem_write_in; m_wb = wb_en_in;
            m_s = s_in; m_b = b_in; m_valid = valid_in;
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        exe_cmd_in       = 4'($urandom);
        mem_read_in      = 1'($urandom);
        mem_write_in     = mem_read_in ? 1'b0 : 1'($urandom);
        wb_en_in         = 1'($urandom);
        s_in             = 1'($urandom);
        b_in             = 1'($urandom);
        pc_in            = $urandom;
        val_rn_in        = $urandom;
        val_rm_in        = $urandom;
        imm_in           = 1'($urandom);
        shift_operand_in = 12'($urandom);
        simm24_in        = 24'($urandom);
        dest_in          = 4'($urandom);
        src1_in          = 4'($urandom);
        src2_in          = 4'($urandom);
        carry_in         = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0; freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
        valid_in = 1'b1; cond_pass = 1'b1;
        rand_data();
        model_zero(1'b1);
        #2;
        total++;
        if (obs !== '0) $display("FAIL reset_initial: got %h expected 0", obs);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (obs !== '0) $display("FAIL reset_held_edge: got %h expected 0", obs);
        else passed++;
        rst = 1'b1;
        rand_data(); pc_in = 32'h10;
        tick();
        total++;
        if (pc_out !== 32'h10 || obs !== expv())
            $display("FAIL reset_first_capture: got %h expected %h", obs, expv());
        else passed++;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            tick();
        end
        rst = 1'b0;
        #1;
        model_zero(1'b1);
        total++;
        if (obs !== '0) $display("FAIL reset_async_mid: got %h expected 0", obs);
        else passed++;
        #1;
        rst = 1'b1;
        rand_data(); pc_in = 32'h10;
        tick();
        total++;
        if (pc_out !== 32'h10 || obs !== expv())
            $display("FAIL reset_release_pc: got %h expected %h", obs, expv());
        else passed++;
    endtask

    task automatic test_normal_load();
        rand_data();
        exe_cmd_in = 4'b0000; mem_read_in = 1'b0; mem_write_in = 1'b0;
        wb_en_in = 1'b1; s_in = 1'b1; b_in = 1'b0;
        val_rn_in = 32'd5; val_rm_in = 32'd7; dest_in = 4'd3;
        valid_in = 1'b1; cond_pass = 1'b1;
        tick();
        total++;
        if ({exe_cmd_out, wb_en_out, s_out, dest_out, valid_out, val_rn_out, val_rm_out}
            !== {4'b0000, 1'b1, 1'b1, 4'd3, 1'b1, 32'd5, 32'd7})
            $display("FAIL normal_add: cmd=%b wb=%b s=%b dest=%0d valid=%b rn=%0d rm=%0d",
                     exe_cmd_out, wb_en_out, s_out, dest_out, valid_out, val_rn_out, val_rm_out);
        else passed++;
        total++;
        if (obs !== expv()) $display("FAIL normal_full: got %h expected %h", obs, expv());
        else passed++;
    endtask

    task automatic test_freeze_over_flush();
        logic [VW-1:0] held;
        logic [VW-1:0] cleared;
        rand_data(); valid_in = 1'b1; cond_pass = 1'b1;
        tick();
        held = expv();
        freeze = 1'b1; flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            tick();
            total++;
            if (obs !== held) $display("FAIL freeze_hold_%0d: got %h expected %h", i, obs, held);
            else passed++;
        end
        freeze = 1'b0;
        rand_data();
        cleared = '0;
        cleared[15:0] = held[15:0];
        tick();
        total++;
        if (obs !== cleared || valid_out !== 1'b0)
            $display("FAIL flush_after_freeze: got %h expected %h", obs, cleared);
        else passed++;
        flush = 1'b0;
    endtask

    task automatic test_hazard();
        rand_data();
        exe_cmd_in = 4'b1010; mem_read_in = 1'b1; mem_write_in = 1'b0;
        wb_en_in = 1'b1; b_in = 1'b0; valid_in = 1'b1; cond_pass = 1'b1;
        hazard = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({exe_cmd_out, mem_read_out, mem_write_out, wb_en_out, s_out, b_out, valid_out} !== '0
                || bubble_cnt !== 16'(i + 1) || obs !== expv())
                $display("FAIL hazard_bubble_%0d: got %h expected %h", i, obs, expv());
            else passed++;
        end
        hazard = 1'b0;
        tick();
        total++;
        if ({mem_read_out, wb_en_out, valid_out, exe_cmd_out} !== {3'b111, 4'b1010}
            || bubble_cnt !== 16'd4)
            $display("FAIL hazard_release_ldr: mr=%b wb=%b valid=%b cmd=%b cnt=%0d",
                     mem_read_out, wb_en_out, valid_out, exe_cmd_out, bubble_cnt);
        else passed++;
    endtask

    task automatic test_cond_fail();
        rand_data();
        exe_cmd_in = 4'b1011; mem_read_in = 1'b0; mem_write_in = 1'b1; b_in = 1'b0;
        valid_in = 1'b1; cond_pass = 1'b0;
        tick();
        total++;
        if ({mem_write_out, valid_out, exe_cmd_out, wb_en_out} !== {1'b0, 1'b1, 4'b1011, 1'b0}
            || obs !== expv())
            $display("FAIL cond_fail_str: got %h expected %h", obs, expv());
        else passed++;
        cond_pass = 1'b1;
    endtask

    task automatic test_branch_x();
        rand_data();
        b_in = 1'b1; exe_cmd_in = 4'bxxxx; valid_in = 1'b1; cond_pass = 1'b1;
        tick();
        total++;
        if (exe_cmd_out !== 4'b0000 || b_out !== 1'b1)
            $display("FAIL branch_x_cmd: cmd=%b b=%b expected cmd=0000 b=1", exe_cmd_out, b_out);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_data();
            freeze    = ($urandom_range(7) == 0);
            flush     = ($urandom_range(7) == 0);
            hazard    = ($urandom_range(3) == 0);
            valid_in  = 1'($urandom);
            cond_pass = ($urandom_range(3) != 0);
            tick();
            total++;
            if (obs !== expv()) $display("FAIL random_%0d: got %h expected %h", i, obs, expv());
            else passed++;
        end
        freeze = 1'b0; flush = 1'b0; hazard = 1'b0; cond_pass = 1'b1;
    endtask

    task automatic test_saturation();
        rand_data();
        hazard = 1'b1;
        while (m_cnt < 65534) tick();
        total++;
        if (bubble_cnt !== 16'hFFFE) $display("FAIL sat_preload: got %h expected fffe", bubble_cnt);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bubble_cnt !== 16'hFFFF) $display("FAIL sat_hold_%0d: got %h expected ffff", i, bubble_cnt);
            else passed++;
        end
        hazard = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_freeze_over_flush();
        test_hazard();
        test_cond_fail();
        test_branch_x();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_exe_reg.md
# id_exe_reg

ID/EXE pipeline register of the 5-stage ARM core. Captures the decoded control word from the control unit plus the ID-stage operands every cycle and presents them to the EXE stage. It implements four pipeline-control actions with a fixed priority:

- global freeze (memory stall),
- branch flush,
- hazard bubble,
- condition-fail squash.

## Interface
Parameters:
- `DW`, 32: data/PC width
- `RW`, 4: register-index width

Ports:
- `clk` in 1: core clock, rising edge
- `rst` in 1: asynchronous, active-low reset (0 = reset)
- `freeze` in 1: hold all contents (memory stall)
- `flush` in 1: branch taken in EXE; discard the ID instruction
- `hazard` in 1: RAW hazard detected; insert bubble
- `cond_pass` in 1: condition check result for the ID instruction
- `exe_cmd_in` in 4: ALU command from the control unit
- `mem_read_in`, `mem_write_in`, `wb_en_in`, `s_in`, `b_in` in 1 each: control bits
- `pc_in`, `val_rn_in`, `val_rm_in` in DW: operands
- `imm_in` in 1: immediate flag
- `shift_operand_in` in 12: shifter operand
- `simm24_in` in 24: branch offset
- `dest_in`, `src1_in`, `src2_in` in RW: register indices (src kept for forwarding)
- `carry_in` in 1: status-register C flag at ID
- `valid_in` in 1: ID holds a real instruction
- One registered `*_out` output per `*_in` data/control port, same width.
- `valid_out` out 1: EXE holds a real instruction
- `bubble_cnt` out 16: saturating count of bubbles inserted

## Operation
Each rising `clk` with `rst`=1 performs exactly one action, chosen in this priority order:
1. `freeze`=1: hold every register, including `bubble_cnt`. `flush` and `hazard` are ignored; the upstream stage keeps them asserted until the freeze is released.
2. `flush`=1: clear. All control bits are 0, `exe_cmd_out`=0, `valid_out`=0, data fields are 0.
3. `hazard`=1: bubble. Control bits and `exe_cmd_out` are 0, `valid_out`=0, data fields load from inputs (don't-care downstream). `bubble_cnt` increments, saturating at 16'hFFFF.
4. `valid_in`=1 and `cond_pass`=0: squash.
   - `wb_en`, `mem_read`, `mem_write`, `s`, `b` all load 0.
   - `exe_cmd`, data fields and `valid_out`=1 load from inputs; the instruction retires as an architectural no-op.
5. Otherwise: load every field from its input unchanged.

Further rules:
- `mem_read_in` and `mem_write_in` both high is illegal upstream. The block passes them through and flags it in a simulation-only assertion.
- With `b_in`=1, `exe_cmd_in` may be X. It is stored as 0 so that X never propagates.

## Timing
- Latency is 1 cycle, input to output. Outputs are registered only; there is no combinational path from input to output.
- Reset asserts asynchronously. While `rst`=0, every output is 0, including `valid_out` and `bubble_cnt`.
- Reset deassertion is synchronised externally. The first capture happens on the first rising edge with `rst`=1.
- Reset mid-freeze: contents clear immediately. After release, normal priority resumes.
- Freeze and flush in the same cycle: freeze wins and the contents hold. The flush takes effect on the first unfrozen edge if it is still asserted.
- Flush and hazard together: flush wins and `bubble_cnt` does not increment.
- `bubble_cnt` at 16'hFFFF with a further hazard: the count stays at 16'hFFFF.

## Structure
- The shared package `arm_pkg` holds:
  - the `exe_cmd_t` encodings (ADD 0000, ADC 0001, SUB 0011, SBC 0100, AND 0101, ORR 0110, EOR 0111, CMP 1000, TST 1001, LDR 1010, STR 1011);
  - the `ctrl_word_t` struct {exe_cmd, mem_read, mem_write, wb_en, s, b};
  - `CTRL_NOP`.
- Sub-module `pipe_reg`, parameterised by width, provides a register with async active-low reset, enable, and synchronous clear. It is instantiated once for the control word and once for the data bundle.
- The action priority is decoded once and drives the enables and clears of both instances.

## Test plan
- Reset: drive `rst`=0 mid-stream with non-zero inputs. Every output reads 0 immediately (asynchronously). After release, `pc_in`=32'h10 appears on `pc_out` one edge later.
- Normal load: ADD with `wb_en`=1, `s`=1, `val_rn`=5, `val_rm`=7, `dest`=3. The next edge shows `exe_cmd_out`=0000, `wb_en_out`=1, `s_out`=1, `dest_out`=3, `valid_out`=1.
- Freeze-over-flush: freeze=1 and flush=1 for 3 cycles, then freeze=0 with flush=1.
  - Contents hold for 3 edges.
  - The next edge clears them with `valid_out`=0.
  - `bubble_cnt` is unchanged throughout.
- Hazard: 4 consecutive hazard cycles on an LDR. Control outputs are 0 and `valid_out`=0 for 4 cycles, and `bubble_cnt` goes from 0 to 4. The LDR then loads with `mem_read_out`=1, `wb_en_out`=1.
- Condition fail: STR with `cond_pass`=0. `mem_write_out`=0, `valid_out`=1, `exe_cmd_out`=1011.
- Saturation: preload `bubble_cnt` to 16'hFFFE and apply 3 hazards. The count reads FFFF, FFFF, FFFF.
